// File: rtl/cpu_defs_pkg.sv
// Shared execute-stage definitions: divider state encoding, latency and
// divide-by-zero quotient pattern.
package cpu_defs_pkg;
  localparam int WIDTH   = 32;
  localparam int CNT_W   = 5;
  localparam int DIV_LAT = 34;
  localparam logic [WIDTH-1:0] DBZ_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/div32_seq_if.sv
// Divider request/response bundle between execute-stage control and div32_seq.
interface div32_seq_if;
  import cpu_defs_pkg::*;
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             ready;
  logic             dbz;

  modport master (output start, sign, a, b, input q, r, busy, ready, dbz);
  modport slave  (input start, sign, a, b, output q, r, busy, ready, dbz);
endinterface

// File: rtl/addsub32.sv
// 32-bit adder/subtractor: s = a + b (sub=0) or a - b (sub=1), with carry out.
module addsub32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] s,
  output logic        cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b ^ {32{sub}}} + {32'd0, sub};
endmodule

// File: rtl/div32_seq.sv
// Non-restoring sequential divider, one quotient bit per cycle, signed or
// unsigned; ready pulses 34 cycles after an accepted start.
module div32_seq
  import cpu_defs_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  div32_seq_if.slave  bus
);
  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     pr;
  logic [WIDTH-1:0]   qr, bb, a_hold;
  logic               neg_q, neg_r, dbz_n;
  logic [WIDTH-1:0]   q_o, r_o;
  logic               dbz_o;

  logic [WIDTH:0]     pr_sh, pr_step;
  logic [WIDTH-1:0]   add_a, sum, r_fix;
  logic               add_sub, cout;

  // PR is 33 bits but the adder is 32; bit 32 is rebuilt from the carry
  // since the zero-extended divisor's top bit is just the sub flag.
  assign pr_sh   = {pr[WIDTH-1:0], qr[WIDTH-1]};
  assign add_a   = (state == S_FIX) ? pr[WIDTH-1:0] : pr_sh[WIDTH-1:0];
  assign add_sub = (state == S_FIX) ? 1'b0 : ~pr[WIDTH];
  assign pr_step = {pr_sh[WIDTH] ^ add_sub ^ cout, sum};
  assign r_fix   = pr[WIDTH] ? sum : pr[WIDTH-1:0];

  addsub32 u_addsub (
    .a    (add_a),
    .b    (bb),
    .sub  (add_sub),
    .s    (sum),
    .cout (cout)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.start) state_nx = S_RUN;
      S_RUN:  if (cnt == CNT_W'(WIDTH-1)) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt    <= '0;
      pr     <= '0;
      qr     <= '0;
      bb     <= '0;
      a_hold <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz_n  <= 1'b0;
      q_o    <= '0;
      r_o    <= '0;
      dbz_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          // 0x8000_0000 negates to itself, which is the right unsigned magnitude
          qr     <= (bus.sign & bus.a[WIDTH-1]) ? ~bus.a + 32'd1 : bus.a;
          bb     <= (bus.sign & bus.b[WIDTH-1]) ? ~bus.b + 32'd1 : bus.b;
          neg_q  <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_r  <= bus.sign & bus.a[WIDTH-1];
          dbz_n  <= (bus.b == '0);
          a_hold <= bus.a;
          pr     <= '0;
          cnt    <= '0;
        end
        S_RUN: begin
          pr  <= pr_step;
          qr  <= {qr[WIDTH-2:0], ~pr_step[WIDTH]};
          cnt <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          if (dbz_n) begin
            q_o   <= DBZ_Q;
            r_o   <= a_hold;
            dbz_o <= 1'b1;
          end else begin
            q_o   <= neg_q ? ~qr + 32'd1 : qr;
            r_o   <= neg_r ? ~r_fix + 32'd1 : r_fix;
            dbz_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.q     = q_o;
  assign bus.r     = r_o;
  assign bus.dbz   = dbz_o;
  assign bus.busy  = (state == S_RUN) || (state == S_FIX);
  assign bus.ready = (state == S_DONE);
endmodule

// File: tb/tb_div32_seq.sv
// Directed-vector bench for div32_seq: latency, busy window, signed/unsigned
// results, divide-by-zero, overflow, start filtering and mid-run reset.
module tb_div32_seq;
  import cpu_defs_pkg::*;

  logic clk = 1'b0;
  logic clrn;
  int   checks = 0;
  int   failures = 0;

  div32_seq_if ifc ();

  div32_seq dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one division; cycle 0 is the start cycle. Returns at the negedge of
  // the ready cycle (or after the budget) so the caller can inspect outputs.
  task automatic do_div(input string tag, input logic sg, input logic [31:0] av,
                        input logic [31:0] bv, input int pulse_at,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz);
    int  lat;
    logic busy_ok;
    @(negedge clk);
    ifc.start = 1'b1; ifc.sign = sg; ifc.a = av; ifc.b = bv;
    @(negedge clk);
    lat = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      if (n == pulse_at) begin
        ifc.start = 1'b1; ifc.a = 32'd50; ifc.b = 32'd3; ifc.sign = 1'b0;
      end else begin
        ifc.start = 1'b0; ifc.a = $urandom; ifc.b = $urandom; ifc.sign = 1'($urandom);
      end
      if (ifc.ready) begin
        lat = n;
        if (ifc.busy) busy_ok = 1'b0;
        break;
      end
      if (ifc.busy !== (n <= 33)) busy_ok = 1'b0;
      @(negedge clk);
    end
    ifc.start = 1'b0;
    chk({tag, ".lat"}, lat, DIV_LAT);
    chk({tag, ".busy"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, ".q"}, ifc.q, eq);
    chk({tag, ".r"}, ifc.r, er);
    chk({tag, ".dbz"}, {31'd0, ifc.dbz}, {31'd0, edbz});
  endtask

  initial begin
    clrn = 1'b0;
    ifc.start = 1'b0; ifc.sign = 1'b0; ifc.a = '0; ifc.b = '0;
    repeat (2) @(negedge clk);
    chk("rst.q", ifc.q, 32'd0);
    chk("rst.r", ifc.r, 32'd0);
    chk("rst.flags", {29'd0, ifc.busy, ifc.ready, ifc.dbz}, 32'd0);
    clrn = 1'b1;

    do_div("u100_7",   1'b0, 32'd100,        32'd7,        0, 32'd14,        32'd2,        1'b0);
    do_div("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,        0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do_div("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE, 0, 32'hFFFF_FFFD, 32'd1,        1'b0);
    do_div("dbz_u",    1'b0, 32'd5,          32'd0,        0, 32'hFFFF_FFFF, 32'd5,        1'b1);
    do_div("dbz_s",    1'b1, 32'd5,          32'd0,        0, 32'hFFFF_FFFF, 32'd5,        1'b1);
    do_div("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 0, 32'h8000_0000, 32'd0,        1'b0);
    do_div("u_max",    1'b0, 32'hFFFF_FFFF,  32'd1,        0, 32'hFFFF_FFFF, 32'd0,        1'b0);
    do_div("s-100_7",  1'b1, 32'hFFFF_FF9C,  32'd7,        0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    do_div("busy_st",  1'b0, 32'd1234,       32'd10,      10, 32'd123,       32'd4,        1'b0);

    // start in the DONE cycle must be ignored; results hold through IDLE
    ifc.start = 1'b1; ifc.a = 32'd9; ifc.b = 32'd3;
    @(negedge clk);
    ifc.start = 1'b0;
    chk("done_st.busy", {31'd0, ifc.busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("hold.q", ifc.q, 32'd123);
    chk("hold.r", ifc.r, 32'd4);

    // back-to-back: the second start lands in the cycle right after ready
    do_div("b2b_1",    1'b0, 32'd81,         32'd9,        0, 32'd9,         32'd0,        1'b0);
    do_div("b2b_2",    1'b0, 32'd82,         32'd9,        0, 32'd9,         32'd1,        1'b0);

    // reset during RUN
    @(negedge clk);
    ifc.start = 1'b1; ifc.sign = 1'b0; ifc.a = 32'd77; ifc.b = 32'd5;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (14) @(negedge clk);
    clrn = 1'b0;
    #1;
    chk("mrst.q", ifc.q, 32'd0);
    chk("mrst.r", ifc.r, 32'd0);
    chk("mrst.flags", {29'd0, ifc.busy, ifc.ready, ifc.dbz}, 32'd0);
    begin
      logic saw_ready;
      saw_ready = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (ifc.ready) saw_ready = 1'b1;
      end
      chk("mrst.noready", {31'd0, saw_ready}, 32'd0);
    end
    clrn = 1'b1;
    do_div("post_rst", 1'b0, 32'd1000,       32'd10,       0, 32'd100,       32'd0,        1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
